// File: rtl/bitwise_logic_pkg.sv
// Shared definitions for the bitwise logic unit.
//   - blu_op_e   : operation select encoding (matches in_op values)
//   - OP_W       : opcode width
//   - blu_s1_t   : stage-1 register layout at the native datapath width
package bitwise_logic_pkg;

    localparam int unsigned OP_W      = 3;
    localparam int unsigned BLU_DATA_W = 16;

    typedef enum logic [OP_W-1:0] {
        BLU_AND    = 3'd0,
        BLU_OR     = 3'd1,
        BLU_XOR    = 3'd2,
        BLU_NAND   = 3'd3,
        BLU_NOR    = 3'd4,
        BLU_XNOR   = 3'd5,
        BLU_ANDN   = 3'd6,
        BLU_PASS_Y = 3'd7
    } blu_op_e;

    typedef struct packed {
        logic [BLU_DATA_W-1:0] result;
        logic                  valid;
    } blu_s1_t;

endpackage

// File: rtl/blu_op_core.sv
// Combinational opcode decode for the bitwise logic unit.
// Ports:
//   op  - operation select (blu_op_e)
//   x   - operand X (already muxed with the accumulator)
//   y   - operand Y
//   res - WIDTH-bit bitwise result
module blu_op_core
    import bitwise_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  blu_op_e          op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        unique case (op)
            BLU_AND:    res = x & y;
            BLU_OR:     res = x | y;
            BLU_XOR:    res = x ^ y;
            BLU_NAND:   res = ~(x & y);
            BLU_NOR:    res = ~(x | y);
            BLU_XNOR:   res = ~(x ^ y);
            BLU_ANDN:   res = x & ~y;
            BLU_PASS_Y: res = y;
            default:    res = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake and a
// chaining accumulator.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   in_valid/in_ready        - operand beat handshake
//   in_op, in_x, in_y        - operation and operands
//   in_use_acc               - take X from the accumulator instead of in_x
//   acc_clr                  - clear accumulator (an accept on the same edge wins)
//   out_valid/out_ready      - result handshake
//   out_res                  - result
//   out_zero/ones/parity     - result flags
// Configuration: define BITWISE_LOGIC_UNIT_FLAGS_EN to build the flag
// registers; otherwise the three flag outputs are tied low.
module bitwise_logic_unit
    import bitwise_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    // Same layout as blu_s1_t, but sized by WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             valid;
    } s1_t;

    s1_t              s1;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] x_eff;
    logic [WIDTH-1:0] core_res;
    logic             accept;
    logic             s2_adv;

    assign s2_adv   = s1.valid && (!out_valid || out_ready);
    assign in_ready = !s1.valid || s2_adv;
    assign accept   = in_valid && in_ready;
    assign x_eff    = in_use_acc ? acc : in_x;

    blu_op_core #(
        .WIDTH (WIDTH)
    ) u_op_core (
        .op  (blu_op_e'(in_op)),
        .x   (x_eff),
        .y   (in_y),
        .res (core_res)
    );

    // Stage 1 and accumulator. The accumulator follows every accepted result
    // so the next beat can chain on it without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= '0;
            acc <= '0;
        end else begin
            if (accept) begin
                s1.result <= core_res;
                s1.valid  <= 1'b1;
                acc       <= core_res;
            end else begin
                if (s2_adv) begin
                    s1.valid <= 1'b0;
                end
                if (acc_clr) begin
                    acc <= '0;
                end
            end
        end
    end

    // Stage 2: output register, held stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= 1'b1;
                out_res   <= s1.result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
    logic zero_q;
    logic ones_q;
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q   <= 1'b0;
            ones_q   <= 1'b0;
            parity_q <= 1'b0;
        end else if (s2_adv) begin
            zero_q   <= ~|s1.result;
            ones_q   <= &s1.result;
            parity_q <= ^s1.result;
        end
    end

    assign out_zero   = zero_q;
    assign out_ones   = ones_q;
    assign out_parity = parity_q;
`else
    assign out_zero   = 1'b0;
    assign out_ones   = 1'b0;
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit.
module tb_bitwise_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_use_acc;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic        out_zero;
    logic        out_ones;
    logic        out_parity;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(
        .WIDTH (16),
        .OP_W  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_use_acc (in_use_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic        ua;
        logic        clr;
    } beat_t;

    beat_t       beats[$];
    logic [15:0] got_res[$];
    logic        got_z[$];
    logic        got_o[$];
    logic        got_p[$];
    int          sent_at_block;
    int          hold_bad;

    // Presents beats in order (holding each until accepted) and records every
    // delivered result. out_ready stays low for the first 'stall' cycles.
    task automatic run_stream(input int stall);
        int          sent;
        int          n;
        logic [15:0] held;
        logic        have_held;
        sent = 0;
        n = beats.size();
        have_held = 1'b0;
        held = '0;
        got_res.delete(); got_z.delete(); got_o.delete(); got_p.delete();
        sent_at_block = -1;
        hold_bad = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (sent >= n && got_res.size() >= n) break;
            @(negedge clk);
            out_ready = (cyc >= stall);
            if (sent < n) begin
                in_valid   = 1'b1;
                in_op      = beats[sent].op;
                in_x       = beats[sent].x;
                in_y       = beats[sent].y;
                in_use_acc = beats[sent].ua;
                acc_clr    = beats[sent].clr;
            end else begin
                in_valid   = 1'b0;
                in_use_acc = 1'b0;
                acc_clr    = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                if (!have_held) begin
                    held = out_res;
                    have_held = 1'b1;
                end else if (out_res !== held) begin
                    hold_bad++;
                end
            end
            if (out_valid && out_ready) begin
                got_res.push_back(out_res);
                got_z.push_back(out_zero);
                got_o.push_back(out_ones);
                got_p.push_back(out_parity);
            end
            if (in_valid && !in_ready && sent_at_block < 0) sent_at_block = sent;
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid   = 1'b0;
        in_use_acc = 1'b0;
        acc_clr    = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0;
        in_use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_res !== 16'h0000) begin errors++; $display("FAIL reset_out_res got=%h exp=0000", out_res); end
        checks++;
        if ({out_zero, out_ones, out_parity} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {out_zero, out_ones, out_parity});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_opcodes;
        logic [15:0] exp_tab[8];
        exp_tab = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF,
                    16'h000F, 16'hF00F, 16'h00F0, 16'hFF00};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = 3'(i); in_x = 16'hF0F0; in_y = 16'hFF00;
            in_use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL op%0d_in_ready got=%b exp=1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_early_valid got=%b exp=0", i, out_valid); end
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_res !== exp_tab[i]) begin
                errors++;
                $display("FAIL op%0d_result got=%b/%h exp=1/%h", i, out_valid, out_res, exp_tab[i]);
            end
        end
    endtask

    task automatic test_acc_clear;
        // Load a non-zero accumulator, clear it with no accept, then read it.
        beats.delete();
        beats.push_back('{3'd7, 16'h0000, 16'hA5A5, 1'b0, 1'b0});
        run_stream(0);
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        beats.delete();
        beats.push_back('{3'd1, 16'hFFFF, 16'h0000, 1'b1, 1'b0});
        run_stream(0);
        checks++;
        if (got_res.size() != 1 || got_res[0] !== 16'h0000) begin
            errors++; $display("FAIL acc_clear_only got_n=%0d exp=0000", got_res.size());
        end
    endtask

    task automatic test_acc_chain;
        logic [15:0] exp_r[3];
        exp_r = '{16'h0001, 16'h0101, 16'h0000};
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        beats.delete();
        beats.push_back('{3'd1, 16'h0001, 16'h0000, 1'b0, 1'b0});
        beats.push_back('{3'd1, 16'hFFFF, 16'h0100, 1'b1, 1'b0});
        beats.push_back('{3'd2, 16'hFFFF, 16'h0101, 1'b1, 1'b0});
        run_stream(0);
        checks++;
        if (got_res.size() != 3) begin
            errors++; $display("FAIL chain_count got=%0d exp=3", got_res.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_res[i] !== exp_r[i]) begin
                    errors++; $display("FAIL chain_res%0d got=%h exp=%h", i, got_res[i], exp_r[i]);
                end
            end
            checks++;
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
            if ({got_z[2], got_o[2], got_p[2]} !== 3'b100) begin
                errors++; $display("FAIL chain_flags got=%b exp=100", {got_z[2], got_o[2], got_p[2]});
            end
`else
            if ({got_z[2], got_o[2], got_p[2]} !== 3'b000) begin
                errors++; $display("FAIL chain_flags got=%b exp=000", {got_z[2], got_o[2], got_p[2]});
            end
`endif
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] exp_v;
        beats.delete();
        for (int i = 0; i < 5; i++) begin
            beats.push_back('{3'd2, 16'(16'h0101 * (i + 1)), 16'h0000, 1'b0, 1'b0});
        end
        run_stream(4);
        checks++;
        if (sent_at_block != 2) begin
            errors++; $display("FAIL bp_block_point got=%0d exp=2", sent_at_block);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++; $display("FAIL bp_hold_stable got=%0d changes exp=0", hold_bad);
        end
        checks++;
        if (got_res.size() != 5) begin
            errors++; $display("FAIL bp_count got=%0d exp=5", got_res.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_v = 16'(16'h0101 * (i + 1));
                checks++;
                if (got_res[i] !== exp_v) begin
                    errors++; $display("FAIL bp_res%0d got=%h exp=%h", i, got_res[i], exp_v);
                end
            end
        end
    endtask

    task automatic test_clr_accept_coincide;
        logic [15:0] exp_r[3];
        exp_r = '{16'h00FF, 16'h0FFF, 16'h0FFF};
        beats.delete();
        beats.push_back('{3'd7, 16'h0000, 16'h00FF, 1'b0, 1'b0});
        beats.push_back('{3'd1, 16'h0000, 16'h0F00, 1'b1, 1'b1});
        beats.push_back('{3'd0, 16'h0000, 16'hFFFF, 1'b1, 1'b0});
        run_stream(0);
        checks++;
        if (got_res.size() != 3) begin
            errors++; $display("FAIL coincide_count got=%0d exp=3", got_res.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_res[i] !== exp_r[i]) begin
                    errors++; $display("FAIL coincide_res%0d got=%h exp=%h", i, got_res[i], exp_r[i]);
                end
            end
        end
    endtask

    task automatic test_flags;
        logic [2:0] exp_f[2];
`ifdef BITWISE_LOGIC_UNIT_FLAGS_EN
        exp_f = '{3'b010, 3'b001};
`else
        exp_f = '{3'b000, 3'b000};
`endif
        beats.delete();
        beats.push_back('{3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0});
        beats.push_back('{3'd7, 16'h0000, 16'h0001, 1'b0, 1'b0});
        run_stream(0);
        checks++;
        if (got_res.size() != 2) begin
            errors++; $display("FAIL flags_count got=%0d exp=2", got_res.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({got_z[i], got_o[i], got_p[i]} !== exp_f[i]) begin
                    errors++; $display("FAIL flags%0d got=%b exp=%b", i, {got_z[i], got_o[i], got_p[i]}, exp_f[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd1; in_x = 16'h1234; in_y = 16'h0000; out_ready = 1'b1;
        @(negedge clk);
        in_x = 16'h00AB; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_res !== 16'h0000 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_state got=%b/%h/%b exp=0/0000/1", out_valid, out_res, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL mid_no_output got=%0d exp=0", seen); end
        beats.delete();
        beats.push_back('{3'd1, 16'hFFFF, 16'h0000, 1'b1, 1'b0});
        run_stream(0);
        checks++;
        if (got_res.size() != 1 || got_res[0] !== 16'h0000) begin
            errors++; $display("FAIL mid_acc_zero got_n=%0d exp=0000", got_res.size());
        end
    endtask

    initial begin
        test_reset();
        test_opcodes();
        test_acc_clear();
        test_acc_chain();
        test_backpressure();
        test_clr_accept_coincide();
        test_flags();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, pipelined bitwise logic unit for the 16-bit processor datapath; successor to the fixed 16-bit single-function OR gate array. It performs one of eight bitwise operations per transaction on WIDTH-bit operands and adds a valid/ready handshake, a two-stage pipeline with backpressure, and an internal accumulator for chaining operations. It sits beside the adder in the ALU and feeds the writeback mux.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- OP_W, 3, opcode width (fixed; exposed for package use)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat
- in_op  in  OP_W  operation select
- in_x  in  WIDTH  operand X
- in_y  in  WIDTH  operand Y
- in_use_acc  in  1  replace X with accumulator value
- acc_clr  in  1  clear accumulator
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_res  out  WIDTH  result
- out_zero  out  1  result == 0
- out_ones  out  1  result == all ones
- out_parity  out  1  XOR-reduction of result

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (X & ~Y), 7 PASS_Y.
- Beat accepted when in_valid && in_ready.
- Stage 1 (S1): on accept, Xeff = in_use_acc ? acc : in_x; result computed combinationally and registered into S1 with s1_valid=1.
- Accumulator: loaded with the S1 result on every accept. acc_clr forces acc to 0 on that edge; if acc_clr and accept coincide, the accept's Xeff uses the pre-clear acc and acc takes the new result (accept wins over clear).
- Stage 2 (S2): S1 content moves to S2 when S2 is empty or being drained; flags computed from the S1 result and registered with it.
- Backpressure: s2_adv = s1_valid && (!out_valid || out_ready); in_ready = !s1_valid || s2_adv. Full throughput (one beat per cycle) when out_ready=1.
- Stalled outputs hold stable (out_res, flags unchanged while out_valid && !out_ready).
- Width rule: all ops are pure bitwise, no carry; WIDTH generalises every vector.

## Timing
- Reset (async assert, sync-clean deassert): s1_valid=0, out_valid=0, out_res=0, out_zero=0, out_ones=0, out_parity=0, acc=0; in_ready=1 on first cycle after reset.
- Latency: beat accepted on edge N → out_valid=1 after edge N+1.
- Back-to-back accumulator ops: beat N+1 with in_use_acc sees beat N's result (no bubble).
- Reset mid-transaction: all in-flight beats discarded, no output produced.
- Both stages full and out_ready=0: in_ready=0; no beat lost or duplicated.

## Configuration
- BITWISE_LOGIC_UNIT_FLAGS_EN defined: out_zero/out_ones/out_parity computed and registered in S2 as above.
- Not defined: flag registers and reduction logic omitted; the three flag outputs tied to 0; ports remain present.

## Structure
- Shared package bitwise_logic_pkg: opcode enum (BLU_AND … BLU_PASS_Y), OP_W constant, S1 stage struct typedef (result + valid).
- One natural sub-module: blu_op_core, combinational opcode decode producing the WIDTH-bit result; pipeline, accumulator and handshake stay in the top.

## Test plan
- Reset: rst_n low mid-stream → out_valid=0, out_res=0, in_ready=1, acc=0 on release.
- Each opcode, X=16'hF0F0, Y=16'hFF00 → AND F000, OR FFF0, XOR 0FF0, NAND 0FFF, NOR 000F, XNOR F00F, ANDN 00F0, PASS FF00; two cycles after accept each.
- Accumulator chain: acc_clr, then OR 16'h0001, OR (use_acc) Y=16'h0100, XOR (use_acc) Y=16'h0101 back-to-back → results 0001, 0101, 0000 (zero=1, parity=0).
- Backpressure: stream 5 beats with out_ready=0 for 4 cycles → in_ready falls after 2 accepts, outputs held stable, all 5 results delivered in order, none dropped.
- Coincident acc_clr and accept: acc=16'h00FF, OR use_acc Y=16'h0F00 with acc_clr=1 → result 0FFF, next use_acc PASS-check shows acc=0FFF.
- Flags with macro on: AND 16'hFFFF, 16'hFFFF → ones=1, zero=0, parity=0; macro off → all flags 0.
